// File: rtl/output_frame_collector.sv
// output_frame_collector: tags conv results with (row,col,kernel) and buffers them in a skid FIFO.
// Define OUTPUT_COLLECTOR_CHECKSUM_EN to build the running rotate-xor checksum.
module output_frame_collector #(
  parameter int OUT_ROWS    = 23,
  parameter int OUT_COLS    = 23,
  parameter int NUM_KERNELS = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int FIFO_DEPTH  = 8,
  localparam int KW = NUM_KERNELS > 1 ? $clog2(NUM_KERNELS) : 1,
  localparam int CW = OUT_COLS > 1 ? $clog2(OUT_COLS) : 1,
  localparam int RW = OUT_ROWS > 1 ? $clog2(OUT_ROWS) : 1
) (
  input  logic                  clk_100MHz,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [KW-1:0]         m_kernel,
  output logic [CW-1:0]         m_col,
  output logic [RW-1:0]         m_row,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  last_err,
  output logic [31:0]           beat_count,
  output logic [31:0]           checksum
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int TW   = RW + CW + KW + DATA_WIDTH;
  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;
  state_t r_state, w_next;
  logic [KW-1:0] r_kern;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNTW-1:0] r_cnt, w_cnt_nxt;
  logic r_full, r_empty, r_last_err;
  logic [31:0] r_beat;
  logic [TW-1:0] r_mem [FIFO_DEPTH];
  logic w_push, w_pop, w_arm, w_kern_wrap, w_col_wrap, w_final;
  assign w_arm       = r_state == IDLE && start;
  assign w_push      = s_valid && s_ready;
  assign w_pop       = !r_empty && m_ready;
  assign w_kern_wrap = r_kern == KW'(NUM_KERNELS - 1);
  assign w_col_wrap  = r_col == CW'(OUT_COLS - 1);
  assign w_final     = w_kern_wrap && w_col_wrap && r_row == RW'(OUT_ROWS - 1);
  assign w_cnt_nxt   = r_cnt + CNTW'(w_push) - CNTW'(w_pop);
  always_ff @(posedge clk_100MHz or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? COLLECT : IDLE;
      COLLECT: w_next = (w_push && w_final) ? DRAIN : COLLECT;
      DRAIN:   w_next = r_empty ? IDLE : DRAIN;
      default: w_next = IDLE;
    endcase
  end
  // s_ready looks only at the registered full flag, so a same-cycle pop never reopens it
  always_comb begin
    busy       = r_state != IDLE;
    s_ready    = r_state == COLLECT && !r_full;
    frame_done = r_state == DRAIN && r_empty;
  end
  always_ff @(posedge clk_100MHz or negedge rst_n)
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_kern     <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_beat     <= '0;
      r_last_err <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_full  <= w_cnt_nxt == CNTW'(FIFO_DEPTH);
      r_empty <= w_cnt_nxt == '0;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_arm) begin
        r_kern     <= '0;
        r_col      <= '0;
        r_row      <= '0;
        r_beat     <= '0;
        r_last_err <= 1'b0;
      end else if (w_push) begin
        r_kern     <= w_kern_wrap ? '0 : r_kern + KW'(1);
        r_col      <= !w_kern_wrap ? r_col : w_col_wrap ? '0 : r_col + CW'(1);
        r_row      <= (w_kern_wrap && w_col_wrap) ? r_row + RW'(1) : r_row;
        r_beat     <= r_beat + 32'(r_beat != '1);
        r_last_err <= r_last_err | (s_last ^ w_final);
      end
    end
  always_ff @(posedge clk_100MHz)
    if (w_push) r_mem[r_wr_ptr] <= {r_row, r_col, r_kern, s_data};
  assign {m_row, m_col, m_kernel, m_data} = r_empty ? '0 : r_mem[r_rd_ptr];
  assign m_valid    = !r_empty;
  assign last_err   = r_last_err;
  assign beat_count = r_beat;
`ifdef OUTPUT_COLLECTOR_CHECKSUM_EN
  logic [31:0] r_checksum;
  always_ff @(posedge clk_100MHz or negedge rst_n)
    if (!rst_n) r_checksum <= '0;
    else if (w_arm) r_checksum <= '0;
    else if (w_push) r_checksum <= {r_checksum[30:0], r_checksum[31]} ^ 32'(s_data);
  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif
endmodule

// File: tb/tb_output_frame_collector.sv
// tb_output_frame_collector: directed frames on a default-sized collector plus a 1x1x3 checksum instance.
module tb_output_frame_collector;
  localparam int N = 23 * 23 * 4;
`ifdef OUTPUT_COLLECTOR_CHECKSUM_EN
  localparam bit CK_ON = 1'b1;
`else
  localparam bit CK_ON = 1'b0;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0, start = 1'b0, s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b0;
  logic [15:0] s_data = '0;
  logic s_ready, m_valid, busy, frame_done, last_err;
  logic [15:0] m_data;
  logic [1:0] m_kernel;
  logic [4:0] m_col, m_row;
  logic [31:0] beat_count, checksum;
  logic c_start = 1'b0, c_valid = 1'b0, c_last = 1'b0;
  logic [15:0] c_data = '0;
  logic c_ready, c_m_valid, c_busy, c_done, c_last_err;
  logic [15:0] c_m_data;
  logic [1:0] c_m_kernel;
  logic c_m_col, c_m_row;
  logic [31:0] c_beat_count, c_checksum;
  output_frame_collector dut (
    .clk_100MHz(clk), .rst_n(rst_n), .start(start),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_kernel(m_kernel), .m_col(m_col), .m_row(m_row),
    .busy(busy), .frame_done(frame_done), .last_err(last_err),
    .beat_count(beat_count), .checksum(checksum)
  );
  output_frame_collector #(.OUT_ROWS(1), .OUT_COLS(1), .NUM_KERNELS(3)) dut_small (
    .clk_100MHz(clk), .rst_n(rst_n), .start(c_start),
    .s_valid(c_valid), .s_ready(c_ready), .s_data(c_data), .s_last(c_last),
    .m_valid(c_m_valid), .m_ready(1'b1), .m_data(c_m_data),
    .m_kernel(c_m_kernel), .m_col(c_m_col), .m_row(c_m_row),
    .busy(c_busy), .frame_done(c_done), .last_err(c_last_err),
    .beat_count(c_beat_count), .checksum(c_checksum)
  );
  int n_tests = 0, n_fail = 0;
  int idx, pops, tag_errs;
  bit done_seen;
  logic [11:0] last_tag;
  logic [31:0] ck;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask
  // Streams one frame; beat i carries data i, expected tag order is kernel-fastest from (0,0,0).
  task automatic run_frame(input int err_at, input int rst_at, input int hold, input int mid_start);
    int cyc = 0;
    idx = 0; pops = 0; tag_errs = 0; done_seen = 1'b0; ck = '0; last_tag = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    while (cyc < 10000) begin
      logic acc, pop;
      s_valid = idx < N;
      s_data  = 16'(idx);
      s_last  = idx == N - 1 || idx == err_at;
      m_ready = cyc >= hold;
      start   = cyc == mid_start;
      if (hold > 0 && cyc == hold) begin
        check("hold_accepted", idx, 8);
        check("hold_s_ready", {31'd0, s_ready}, 0);
      end
      if (frame_done) begin
        done_seen = 1'b1;
        break;
      end
      acc = s_valid && s_ready;
      pop = m_valid && m_ready;
      if (pop) begin
        if (m_kernel != 2'(pops % 4) || m_col != 5'((pops / 4) % 23) || m_row != 5'(pops / 92) || m_data != 16'(pops))
          tag_errs++;
        last_tag = {m_row, m_col, m_kernel};
        pops++;
      end
      if (acc) ck = {ck[30:0], ck[31]} ^ 32'(s_data);
      step();
      cyc++;
      if (acc) idx++;
      if (idx == rst_at) begin
        check("pre_rst_beat_count", beat_count, 50);
        rst_n = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_m_valid", {31'd0, m_valid}, 0);
        check("rst_s_ready", {31'd0, s_ready}, 0);
        check("rst_beat_count", beat_count, 0);
        check("rst_checksum", checksum, 0);
        repeat (3) begin
          step();
          if (frame_done) done_seen = 1'b1;
        end
        rst_n = 1'b1;
        break;
      end
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    start = 1'b0;
  endtask
  initial begin
    m_ready = 1'b1;
    #12;
    check("reset_busy", {31'd0, busy}, 0);
    check("reset_s_ready", {31'd0, s_ready}, 0);
    check("reset_m_valid", {31'd0, m_valid}, 0);
    check("reset_frame_done", {31'd0, frame_done}, 0);
    check("reset_last_err", {31'd0, last_err}, 0);
    check("reset_beat_count", beat_count, 0);
    check("reset_checksum", checksum, 0);
    rst_n = 1'b1;
    step();
    check("idle_s_ready", {31'd0, s_ready}, 0);
    run_frame(-1, -1, 0, 20);
    check("full_done", {31'd0, done_seen}, 1);
    check("full_pops", pops, N);
    check("full_tag_order", tag_errs, 0);
    check("full_last_tag", {20'd0, last_tag}, {20'd0, 5'd22, 5'd22, 2'd3});
    check("full_last_err", {31'd0, last_err}, 0);
    check("full_beat_count", beat_count, N);
    check("full_checksum", checksum, CK_ON ? ck : 32'd0);
    check("full_busy_in_drain", {31'd0, busy}, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_in_done_ignored", {31'd0, busy}, 0);
    check("done_single_pulse", {31'd0, frame_done}, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_after_done", {31'd0, busy}, 1);
    check("start_clears_count", beat_count, 0);
    do_reset();
    run_frame(-1, -1, 12, -1);
    check("hold_done", {31'd0, done_seen}, 1);
    check("hold_tag_order", tag_errs, 0);
    check("hold_pops", pops, N);
    do_reset();
    run_frame(99, -1, 0, -1);
    check("err_done", {31'd0, done_seen}, 1);
    check("err_pops", pops, N);
    check("err_last_err", {31'd0, last_err}, 1);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("err_cleared_by_start", {31'd0, last_err}, 0);
    do_reset();
    run_frame(-1, 50, 0, -1);
    check("rst_no_frame_done", {31'd0, done_seen}, 0);
    check("rst_idle_after", {31'd0, busy}, 0);
    run_frame(-1, -1, 0, -1);
    check("after_rst_done", {31'd0, done_seen}, 1);
    check("after_rst_tag_order", tag_errs, 0);
    check("after_rst_pops", pops, N);
    c_start = 1'b1;
    step();
    c_start = 1'b0;
    c_valid = 1'b1;
    c_data = 16'h0001;
    step();
    c_data = 16'h0002;
    step();
    c_data = 16'h0003;
    c_last = 1'b1;
    step();
    c_valid = 1'b0;
    c_last = 1'b0;
    check("small_beat_count", c_beat_count, 3);
    check("small_checksum", c_checksum, CK_ON ? 32'h3 : 32'h0);
    check("small_last_err", {31'd0, c_last_err}, 0);
    repeat (6) step();
    check("small_idle", {31'd0, c_busy}, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/output_frame_collector.md
OUTPUT_FRAME_COLLECTOR -- requirements
Module: output_frame_collector

Interface
REQ-001 SHALL have parameter OUT_ROWS, default 23, output feature-map rows per frame.
REQ-002 SHALL have parameter OUT_COLS, default 23, output feature-map columns per frame.
REQ-003 SHALL have parameter NUM_KERNELS, default 4, kernel outputs per pixel.
REQ-004 SHALL have parameter DATA_WIDTH, default 16, result word width.
REQ-005 SHALL have parameter FIFO_DEPTH, default 8, skid FIFO entries; must be a power of two and at least 2.
REQ-006 SHALL have port clk_100MHz  in  1  sole clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-008 SHALL have port start  in  1  one-cycle pulse that arms collection of one frame.
REQ-009 SHALL have ports s_valid in 1, s_ready out 1, s_data in DATA_WIDTH, s_last in 1: result stream from the conv engine.
REQ-010 SHALL have ports m_valid out 1, m_ready in 1, m_data out DATA_WIDTH: drained result stream.
REQ-011 SHALL have ports m_kernel, m_col, m_row: out, $clog2 of NUM_KERNELS, OUT_COLS and OUT_ROWS (min 1): position tag of m_data.
REQ-012 SHALL have ports busy out 1, frame_done out 1, last_err out 1, beat_count out 32, checksum out 32.

Function
REQ-013 SHALL have FSM states IDLE, COLLECT, DRAIN.
REQ-014 IDLE: s_ready=0; start -> COLLECT next cycle. Entry clears the counters, beat_count, last_err and checksum.
REQ-015 Start in COLLECT or DRAIN SHALL be ignored.
REQ-016 COLLECT: s_ready = FIFO not full (registered full flag). A beat is accepted when s_valid&&s_ready.
REQ-017 Each accepted beat SHALL be pushed with its tag. Tag order: kernel fastest, then col, then row, all starting at 0.
REQ-018 Counters SHALL wrap: kernel NUM_KERNELS-1 -> 0 increments col; col OUT_COLS-1 -> 0 increments row.
REQ-019 The final beat is tag (OUT_ROWS-1, OUT_COLS-1, NUM_KERNELS-1). Its acceptance SHALL move the FSM to DRAIN next cycle.
REQ-020 last_err SHALL set (sticky until the next start) when s_last on an accepted beat disagrees with "final beat".
REQ-021 DRAIN: s_ready=0; when the FIFO is empty, frame_done SHALL pulse one cycle and the FSM returns to IDLE.
REQ-022 busy SHALL be 1 in COLLECT and DRAIN, 0 in IDLE.
REQ-023 m_valid = FIFO not empty. Pop on m_valid&&m_ready. m_data and the tags SHALL be held stable while m_valid&&!m_ready.
REQ-024 Latency: an accepted beat SHALL be visible on m_valid no earlier than the following cycle, with no combinational s-to-m path.
REQ-025 Simultaneous push and pop SHALL keep the occupancy unchanged. When full, s_ready=0 even if a pop occurs in the same cycle.
REQ-026 beat_count SHALL increment on each accepted beat and saturate at 2^32-1.

Reset
REQ-027 rst_n low SHALL immediately force the FSM to IDLE and set all of these to 0: FIFO pointers, counters, s_ready, m_valid, busy, frame_done, last_err, beat_count, checksum.
REQ-028 Reset mid-frame SHALL discard FIFO contents. Collection resumes only on a new start after rst_n deasserts.

Configuration
REQ-029 With macro OUTPUT_COLLECTOR_CHECKSUM_EN defined, each accepted beat SHALL update checksum = rotl1(checksum) XOR zero-extended s_data.
REQ-030 Without OUTPUT_COLLECTOR_CHECKSUM_EN, checksum SHALL be constant 0 and the checksum logic is absent.

Verification
REQ-031 Full frame with defaults, s_valid always 1 and m_ready always 1, s_last on beat 2116 -> 2116 beats out, last tag (22,22,3), one frame_done, last_err=0, beat_count=2116.
REQ-032 m_ready=0 during collection -> exactly 8 beats accepted, then s_ready=0. Raising m_ready drains tags (0,0,0)..(0,1,3) in order.
REQ-033 s_last asserted on beat 100 -> last_err=1 and the collection continues to 2116. A new start clears last_err.
REQ-034 rst_n pulsed low after beat 50 -> all outputs 0 asynchronously, m_valid=0, no frame_done. The next start restarts the tags at (0,0,0).
REQ-035 With OUTPUT_COLLECTOR_CHECKSUM_EN, data 0x0001, 0x0002, 0x0003 on a 1x1x3 configuration -> checksum 0x00000003 ((1<<1)^2=0, then (0<<1)^3=3). Without the macro -> checksum 0.
REQ-036 start pulsed during COLLECT -> no effect on the counters. Start in the frame_done cycle (IDLE next) is accepted on the following cycle only.
